param_assoc_cache: RTL

- Parametrised, fully associative, write-through data cache sitting between the accumulator processor's MAR/MDR datapath and the data RAM.
- Successor to the fixed 4-line, 8-bit data cache, with configurable line count, data width and address width.
- Adds a req/ready/done handshake on both the CPU side and the memory side, true-LRU replacement, and a single-cycle flush.

---
 rtl/param_assoc_cache_pkg.sv | 17 +
 rtl/param_assoc_cache_lru_age_tracker.sv | 52 +++++
 rtl/param_assoc_cache.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/param_assoc_cache_pkg.sv
// Shared types and constants for the parametrised fully associative write-through cache.
package param_cache_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLookup = 3'd1,
    StFill   = 3'd2,
    StWrite  = 3'd3,
    StDone   = 3'd4
  } cache_state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int unsigned STAT_W = 16;

endpackage

// File: rtl/param_assoc_cache_lru_age_tracker.sv
// True-LRU age array: age 0 is most recent, NUM_LINES-1 is least recent.
module lru_age_tracker #(
  parameter int unsigned NUM_LINES = 4,
  parameter int unsigned IDX_W     = $clog2(NUM_LINES)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 touch_en_i,
  input  logic [IDX_W-1:0]     touch_idx_i,
  input  logic                 reset_ages_i,
  input  logic [NUM_LINES-1:0] valid_i,
  output logic [IDX_W-1:0]     victim_idx_o
);

  logic [IDX_W-1:0] age_q [NUM_LINES];
  logic [IDX_W-1:0] age_d [NUM_LINES];

  always_comb begin
    age_d = age_q;
    if (reset_ages_i) begin
      for (int unsigned i = 0; i < NUM_LINES; i++) age_d[i] = IDX_W'(i);
    end else if (touch_en_i) begin
      for (int unsigned i = 0; i < NUM_LINES; i++) begin
        if (IDX_W'(i) == touch_idx_i) begin
          age_d[i] = '0;
        end else if (age_q[i] < age_q[touch_idx_i]) begin
          age_d[i] = age_q[i] + IDX_W'(1);
        end
      end
    end
  end

  // Invalid lines take precedence; scanning downwards leaves the lowest index.
  always_comb begin
    victim_idx_o = '0;
    for (int unsigned i = 0; i < NUM_LINES; i++) begin
      if (age_q[i] == IDX_W'(NUM_LINES - 1)) victim_idx_o = IDX_W'(i);
    end
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (!valid_i[i]) victim_idx_o = IDX_W'(i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_LINES; i++) age_q[i] <= IDX_W'(i);
    end else begin
      age_q <= age_d;
    end
  end

endmodule

// File: rtl/param_assoc_cache.sv
// Fully associative write-through, no-write-allocate data cache with true-LRU replacement.
// Optional hit/miss counters are enabled by defining CACHE_STATS_EN.
module param_assoc_cache
  import param_cache_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned NUM_LINES = 4,
  parameter int unsigned IDX_W     = $clog2(NUM_LINES)
) (
  input  logic              g_clk,
  input  logic              g_clr,
  input  logic              cpu_req,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_flush,
  output logic              cpu_ready,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_hit,
  output logic              mem_req,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
`ifdef CACHE_STATS_EN
  output logic [STAT_W-1:0] stat_hits,
  output logic [STAT_W-1:0] stat_misses,
`endif
  output logic [IDX_W-1:0]  lru_victim,
  output logic [2:0]        fsm_state
);

  cache_state_e state_q, state_d;
  logic rw_q, rw_d, hit_q, hit_d;
  logic [ADDR_W-1:0] addr_q, addr_d, mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d, mem_wdata_q, mem_wdata_d;
  logic cpu_hit_q, cpu_hit_d, mem_rw_q, mem_rw_d;
  logic [IDX_W-1:0] hit_idx_q, hit_idx_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [ADDR_W-1:0] tag_q [NUM_LINES];
  logic [ADDR_W-1:0] tag_d [NUM_LINES];
  logic [DATA_W-1:0] data_q [NUM_LINES];
  logic [DATA_W-1:0] data_d [NUM_LINES];

  logic lookup_hit, touch_en, reset_ages;
  logic [IDX_W-1:0] lookup_idx, touch_idx;

  // Tags are unique among valid lines, so at most one match.
  always_comb begin
    lookup_hit = 1'b0;
    lookup_idx = '0;
    for (int unsigned i = 0; i < NUM_LINES; i++) begin
      if (valid_q[i] && tag_q[i] == addr_q) begin
        lookup_hit = 1'b1;
        lookup_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    hit_d       = hit_q;
    hit_idx_d   = hit_idx_q;
    rdata_d     = rdata_q;
    cpu_hit_d   = cpu_hit_q;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    data_d      = data_q;
    touch_en    = 1'b0;
    touch_idx   = '0;
    reset_ages  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cpu_flush) begin
          valid_d    = '0;
          reset_ages = 1'b1;
        end else if (cpu_req) begin
          rw_d    = cpu_rw;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          state_d = StLookup;
        end
      end
      StLookup: begin
        hit_d     = lookup_hit;
        hit_idx_d = lookup_idx;
        if (rw_q == RW_READ && lookup_hit) begin
          rdata_d   = data_q[lookup_idx];
          cpu_hit_d = 1'b1;
          touch_en  = 1'b1;
          touch_idx = lookup_idx;
          state_d   = StDone;
        end else if (rw_q == RW_READ) begin
          mem_rw_d   = RW_READ;
          mem_addr_d = addr_q;
          state_d    = StFill;
        end else begin
          mem_rw_d    = RW_WRITE;
          mem_addr_d  = addr_q;
          mem_wdata_d = wdata_q;
          state_d     = StWrite;
        end
      end
      StFill: begin
        if (mem_ack) begin
          valid_d[lru_victim] = 1'b1;
          tag_d[lru_victim]   = addr_q;
          data_d[lru_victim]  = mem_rdata;
          touch_en            = 1'b1;
          touch_idx           = lru_victim;
          rdata_d             = mem_rdata;
          cpu_hit_d           = 1'b0;
          state_d             = StDone;
        end
      end
      StWrite: begin
        if (mem_ack) begin
          if (hit_q) begin
            data_d[hit_idx_q] = wdata_q;
            touch_en          = 1'b1;
            touch_idx         = hit_idx_q;
          end
          cpu_hit_d = hit_q;
          state_d   = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      state_q     <= StIdle;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      hit_q       <= 1'b0;
      hit_idx_q   <= '0;
      rdata_q     <= '0;
      cpu_hit_q   <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      valid_q     <= '0;
      for (int unsigned i = 0; i < NUM_LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      hit_q       <= hit_d;
      hit_idx_q   <= hit_idx_d;
      rdata_q     <= rdata_d;
      cpu_hit_q   <= cpu_hit_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      valid_q     <= valid_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
    end
  end

  lru_age_tracker #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W)
  ) u_lru (
    .clk_i        (g_clk),
    .rst_ni       (g_clr),
    .touch_en_i   (touch_en),
    .touch_idx_i  (touch_idx),
    .reset_ages_i (reset_ages),
    .valid_i      (valid_q),
    .victim_idx_o (lru_victim)
  );

  // mem_req is decoded from state so an asynchronous clear drops it at once.
  assign cpu_ready = (state_q == StIdle);
  assign cpu_done  = (state_q == StDone);
  assign mem_req   = (state_q == StFill) || (state_q == StWrite);
  assign cpu_rdata = rdata_q;
  assign cpu_hit   = cpu_hit_q;
  assign mem_rw    = mem_rw_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign fsm_state = state_q;

`ifdef CACHE_STATS_EN
  logic [STAT_W-1:0] hits_q, hits_d, misses_q, misses_d;

  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    if (state_q == StDone) begin
      if (cpu_hit_q && hits_q != '1) hits_d = hits_q + STAT_W'(1);
      if (!cpu_hit_q && misses_q != '1) misses_d = misses_q + STAT_W'(1);
    end
  end

  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`endif

endmodule
